inst_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read interface. Owns the program counter, drives the word-aligned

---
 rtl/rv_if_pkg.sv | 21 ++
 rtl/if_fetch_queue.sv | 74 +++++++
 rtl/inst_fetch_unit.sv | 121 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_if_pkg.sv
// Shared definitions for the instruction fetch unit: constants, FSM states and fetch-entry layout.
package rv_if_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Two-entry FIFO between fetch and decode; entry 0 is always the head, so head data is a plain register.
module if_fetch_queue #(
    parameter int unsigned         DATA_W    = 64,
    parameter logic [DATA_W-1:0]   EMPTY_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= EMPTY_VAL;
            e1_q    <= EMPTY_VAL;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Flush wins over push; an emptied head is reloaded with EMPTY_VAL so outputs show the idle value.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            e0_d  = EMPTY_VAL;
            e1_d  = EMPTY_VAL;
            cnt_d = 2'd0;
        end else begin
            unique case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = data_i;
                    else               e1_d = data_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = (cnt_q == 2'd2) ? e1_q : EMPTY_VAL;
                    e1_d  = EMPTY_VAL;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = data_i;
                    end else begin
                        e0_d = data_i;
                    end
                end
                default: ;
            endcase
        end
        valid_d = (cnt_d != 2'd0);
    end

    assign valid_o = valid_q;
    assign head_o  = e0_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory, queues {pc, inst} for decode
// and latches a fault on misaligned or out-of-range fetch/redirect addresses.
module inst_fetch_unit
    import rv_if_pkg::*;
#(
    parameter int unsigned         PC_WIDTH      = 32,
    parameter int unsigned         INST_WIDTH    = 32,
    parameter int unsigned         MEM_ADDR_BITS = 20,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_inst,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic [PC_WIDTH-1:0]   if_pc,
    output logic                  fault,
    output logic [PC_WIDTH-1:0]   fault_pc
);

    localparam int unsigned ENTRY_W = PC_WIDTH + INST_WIDTH;
    // Address bits above the memory window; zero mask when memory spans the whole PC space.
    localparam logic [PC_WIDTH-1:0] HI_MASK = (MEM_ADDR_BITS >= PC_WIDTH) ? '0 :
        ~((PC_WIDTH'(1) << MEM_ADDR_BITS) - PC_WIDTH'(1));
    localparam logic [ENTRY_W-1:0] EMPTY_ENTRY = {PC_WIDTH'(0), INST_WIDTH'(NOP_INST)};

    function automatic logic addr_ok(input logic [PC_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && ((a & HI_MASK) == '0);
    endfunction

    if_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  fault_q, fault_d;
    logic [PC_WIDTH-1:0]   fault_pc_q, fault_pc_d;
    logic                  push, pop, flush, space;
    logic [1:0]            q_count;
    logic [ENTRY_W-1:0]    q_head;
    logic                  q_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign pop   = q_valid & if_ready;
    assign space = (q_count != 2'd2) | pop;

    // Redirect overrides everything; otherwise RUN checks the PC before capturing the memory word.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush = 1'b1;
            if (addr_ok(redirect_pc)) begin
                pc_d    = redirect_pc;
                state_d = ST_RUN;
                fault_d = 1'b0;
            end else begin
                state_d    = ST_FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end
        end else begin
            unique case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN: begin
                    if (!addr_ok(pc_q)) begin
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                    end else if (space) begin
                        push = 1'b1;
                        pc_d = pc_q + PC_WIDTH'(PC_STEP);
                    end
                end
                ST_FAULT: ;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    if_fetch_queue #(
        .DATA_W    (ENTRY_W),
        .EMPTY_VAL (EMPTY_ENTRY)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  ({pc_q, imem_inst}),
        .valid_o (q_valid),
        .head_o  (q_head),
        .count_o (q_count)
    );

    assign imem_addr = pc_q;
    assign if_valid  = q_valid;
    assign if_pc     = q_head[ENTRY_W-1:INST_WIDTH];
    assign if_inst   = q_head[INST_WIDTH-1:0];
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_inst_fetch_unit;
    import rv_if_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] MEM_TOP  = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr, imem_inst, redirect_pc, if_inst, if_pc, fault_pc;
    logic        redirect_valid, if_valid, if_ready, fault;
    logic [31:0] w_imem_addr, w_imem_inst, w_redirect_pc, w_if_inst, w_if_pc, w_fault_pc;
    logic        w_redirect_valid, w_if_valid, w_fault;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 32'hzzzz_zzzz;
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F0F};
    endfunction

    assign imem_inst   = mem_word(imem_addr);
    assign w_imem_inst = mem_word(w_imem_addr);

    inst_fetch_unit #(.PC_WIDTH(32), .INST_WIDTH(32), .MEM_ADDR_BITS(20), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc), .fault(fault), .fault_pc(fault_pc));

    // Memory spanning the full PC space, used to observe the 0xFFFFFFFC -> 0x0 wrap without a range fault.
    inst_fetch_unit #(.PC_WIDTH(32), .INST_WIDTH(32), .MEM_ADDR_BITS(32), .RESET_PC(RESET_PC)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_inst(w_imem_inst),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .if_valid(w_if_valid),
        .if_ready(1'b1), .if_inst(w_if_inst), .if_pc(w_if_pc), .fault(w_fault), .fault_pc(w_fault_pc));

    // Reference model state
    logic [31:0]  m_pc, m_fault_pc;
    bit           m_boot, m_fault;
    fetch_entry_t m_q[$];

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < MEM_TOP);
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_fault_pc = 32'h0; m_boot = 1'b1; m_fault = 1'b0;
        m_q.delete();
    endtask

    function automatic logic [129:0] exp_vec();
        fetch_entry_t hd;
        hd.pc = 32'h0; hd.inst = NOP_INST;
        if (m_q.size() != 0) hd = m_q[0];
        return {m_q.size() != 0, hd.pc, hd.inst, m_fault, m_fault_pc, m_pc};
    endfunction

    function automatic logic [129:0] obs_vec();
        return {if_valid, if_pc, if_inst, fault, fault_pc, imem_addr};
    endfunction

    // Advance the model by one cycle using the current inputs, then step the clock.
    task automatic tick();
        bit pop, space;
        pop = (m_q.size() != 0) && if_ready;
        if (redirect_valid) begin
            m_q.delete();
            m_boot = 1'b0;
            if (legal(redirect_pc)) begin m_pc = redirect_pc; m_fault = 1'b0; end
            else begin m_fault = 1'b1; m_fault_pc = redirect_pc; end
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            space = (m_q.size() < 2) || pop;
            if (pop) void'(m_q.pop_front());
            if (!m_fault) begin
                if (!legal(m_pc)) begin m_fault = 1'b1; m_fault_pc = m_pc; end
                else if (space) begin
                    m_q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
        w_redirect_valid = 1'b0; w_redirect_pc = 32'h0;
        model_reset();
        #12;
        n_tests++;
        if (obs_vec() !== {1'b0, 32'h0, NOP_INST, 1'b0, 32'h0, RESET_PC}) begin
            n_fail++; $display("FAIL reset_values: got %h exp %h", obs_vec(),
                               {1'b0, 32'h0, NOP_INST, 1'b0, 32'h0, RESET_PC});
        end
    endtask

    task automatic test_stream();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stream cyc%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
            if (i == 2) begin
                n_tests++;
                if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h0, 32'h0050_0093}) begin
                    n_fail++; $display("FAIL first_fetch: got %h %h exp 0 00500093", if_pc, if_inst);
                end
            end
            if (i == 3) begin
                n_tests++;
                if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h4, 32'h0010_0113}) begin
                    n_fail++; $display("FAIL second_fetch: got %h %h exp 4 00100113", if_pc, if_inst);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] head_pc, got;
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) head_pc = if_pc;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stall cyc%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        n_tests++;
        if ({if_valid, if_pc, imem_addr} !== {1'b1, head_pc, head_pc + 32'd8}) begin
            n_fail++; $display("FAIL stall_hold: got pc %h addr %h exp pc %h addr %h",
                               if_pc, imem_addr, head_pc, head_pc + 32'd8);
        end
        if_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = if_pc;
            n_tests++;
            if (!if_valid || got !== head_pc + 32'(4 * k)) begin
                n_fail++; $display("FAIL drain_order k%0d: got %h exp %h", k, got, head_pc + 32'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        if_ready = 1'b0; tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100; if_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_flush: got valid %b exp 0", if_valid); end
        tick();
        n_tests++;
        if ({if_valid, if_pc} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL redirect_head: got %b %h exp 1 100", if_valid, if_pc);
        end
        tick();
        n_tests++;
        if (obs_vec() !== exp_vec() || if_pc !== 32'h104) begin
            n_fail++; $display("FAIL redirect_next: got %h exp %h (pc 104)", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if ({fault, fault_pc, if_valid} !== {1'b1, 32'h102, 1'b0}) begin
            n_fail++; $display("FAIL misalign_fault: got %b %h %b exp 1 102 0", fault, fault_pc, if_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec() || if_valid !== 1'b0) begin
                n_fail++; $display("FAIL fault_frozen cyc%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b exp 0", fault); end
        tick();
        n_tests++;
        if ({if_valid, if_pc, imem_addr} !== {1'b1, 32'h200, 32'h204}) begin
            n_fail++; $display("FAIL resume: got %b %h %h exp 1 200 204", if_valid, if_pc, imem_addr);
        end
    endtask

    task automatic test_range();
        bit seen_last;
        seen_last = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h000F_FFF0;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (if_valid && if_pc === 32'h000F_FFFC) seen_last = 1'b1;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL range cyc%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        n_tests++;
        if ({seen_last, fault, fault_pc} !== {1'b1, 1'b1, 32'h0010_0000}) begin
            n_fail++; $display("FAIL range_fault: got seen %b %b %h exp 1 1 00100000", seen_last, fault, fault_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if ({fault, fault_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL range_redirect: got %b %h exp 1 fffffffc", fault, fault_pc);
        end
        w_redirect_valid = 1'b1; w_redirect_pc = 32'hFFFF_FFFC;
        tick();
        w_redirect_valid = 1'b0;
        tick();
        n_tests++;
        if ({w_if_valid, w_if_pc, w_if_inst, w_imem_addr, w_fault} !==
            {1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL wrap_word: got %b %h %h %h %b", w_if_valid, w_if_pc, w_if_inst, w_imem_addr, w_fault);
        end
        tick();
        n_tests++;
        if ({w_if_valid, w_if_pc, w_fault, w_fault_pc} !== {1'b1, 32'h0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL wrap_zero: got %b %h %b %h exp 1 0 0 0", w_if_valid, w_if_pc, w_fault, w_fault_pc);
        end
    endtask

    task automatic test_reset_mid();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0; if_ready = 1'b0;
        tick(); tick(); tick();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (obs_vec() !== {1'b0, 32'h0, NOP_INST, 1'b0, 32'h0, RESET_PC}) begin
            n_fail++; $display("FAIL async_reset: got %h exp %h", obs_vec(),
                               {1'b0, 32'h0, NOP_INST, 1'b0, 32'h0, RESET_PC});
        end
        #2 rst_n = 1'b1; if_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                n_tests++;
                if ({if_valid, if_pc} !== {1'b1, RESET_PC}) begin
                    n_fail++; $display("FAIL restart_pc: got %b %h exp 1 %h", if_valid, if_pc, RESET_PC);
                end
            end
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL restart cyc%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'($urandom_range(0, 1023)) * 32'd4;
                1:       redirect_pc = 32'($urandom_range(0, 1023)) * 32'd4 + 32'($urandom_range(1, 3));
                2:       redirect_pc = MEM_TOP + 32'($urandom_range(0, 255)) * 32'd4;
                default: redirect_pc = MEM_TOP - 32'($urandom_range(1, 4)) * 32'd4;
            endcase
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc%0d: got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misalign();
        test_range();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
